ntru_conv_seq: RTL and testbench
================================

# ntru_conv_seq

Sequencer that computes the NTRU cyclic convolution c = a·b mod (x^N − 1), with coefficients mod 2^11. It drives a single 11-bit multiply-accumulate unit (acc + x·y mod 2048) over three synchronous coefficient RAMs. It sits between the AXI register/BRAM wrapper of the 11-bit multiplier IP and the arithmetic unit, and replaces software-issued per-coefficient MAC calls.

## Interface
- `N`, default 509: polynomial degree / coefficient count; legal range 4..2048.
- `AW`, default $clog2(N): RAM address width.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse when the c RAM holds the final result.
- `a_addr` out AW: a RAM read address (registered).
- `a_data` in 11: a RAM read data, valid 1 cycle after address.
- `b_addr` out AW: b RAM read address (registered).
- `b_data` in 11: b RAM read data, valid 1 cycle after address.
- `c_raddr` out AW: c RAM read address (registered).
- `c_rdata` in 11: c RAM read data, valid 1 cycle after address.
- `c_waddr` out AW: c RAM write address (registered).
- `c_wdata` out 11: c RAM write data (registered).
- `c_we` out 1: c RAM write enable (registered).

## Operation
- States: IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
- IDLE: outputs quiescent. `start`=1 moves to CLEAR, clears counters, and raises `busy`.
- CLEAR: N cycles. Each cycle writes `c_we`=1, `c_wdata`=0, with `c_waddr` counting 0..N−1. Then RUN.
- RUN: N·N issue cycles with i outer (0..N−1), j inner (0..N−1), k=(i+j) mod N.
  - Each issue cycle presents `a_addr`=i, `b_addr`=j, `c_raddr`=k.
  - k is kept as its own wrapping counter: +1 per j, wraps N−1→0, and reloads to i+1 (wrapped) at each row end. No divider.
- Pipeline, for each issue at cycle t:
  - t+1: RAM data arrives; the MAC computes c_rdata + a_data·b_data mod 2048.
  - t+2: result is driven on `c_wdata`/`c_waddr`=k with `c_we`=1.
- DRAIN: 2 cycles to flush the last issue. No new reads are issued.
- DONE: 1 cycle; `done`=1 and `busy`=0. Then IDLE.
- Arithmetic: all sums and products are truncated to 11 bits (mod q=2048). There is no carry-out and no saturation.
- Hazard rule: the same k is never re-read within 2 cycles of its write. This holds because consecutive issues hit distinct addresses for N≥4. No forwarding logic is required, and N<4 is illegal.
- `start` while not IDLE is ignored; there is no queueing.
- A new run always clears c first, so prior contents never leak into the result.

## Timing
- Reset values: `busy`=0, `done`=0, `c_we`=0; all addresses and `c_wdata`=0; state IDLE.
- `rst` mid-operation aborts immediately. c RAM contents are undefined afterwards; the next start fully recomputes them.
- Start edge = cycle 0.
  - CLEAR writes occupy cycles 1..N.
  - RUN issues occupy cycles N+1..N+N².
  - The last write is in cycle N+N²+2.
  - `done` pulses in cycle N+N²+3.
- `busy` is high in cycles 1..N+N²+2.
- Throughput: one MAC per cycle in RUN; no bubbles at row boundaries.
- `a_addr`, `b_addr` and `c_raddr` hold their last values outside RUN.

## Structure
- Shared package `ntru_pkg`:
  - `Q_BITS`=11.
  - `coef_t` (11-bit coefficient type).
  - State enum `conv_state_t` {IDLE, CLEAR, RUN, DRAIN, DONE}.
- One sub-module: the team's existing 11-bit multiply-accumulate unit (`AU_COMP11x11`), instantiated once with num1=a_data, num2=b_data, num3=c_rdata.
- The sequencer contains the FSM, the i/j/k counters, and the 2-stage valid/address shift for the write-back.

## Test plan
All scenarios use N=4 and behavioural 1-cycle-latency RAMs.
- Identity: a=[1,0,0,0], b=[5,6,7,8] → c=[5,6,7,8]; `done` exactly at cycle 23; `busy` high cycles 1..22.
- Rotation: a=[0,1,0,0], b=[5,6,7,8] → c=[8,5,6,7].
- Modular wrap: a=[2047,2047,2047,2047], b=[1,1,1,1] → every c[k]=2044.
- General: a=[1,2,3,4], b=[4,3,2,1] → c=[24,22,24,30].
- Control:
  - c pre-filled with 0x7FF, then the identity run → c=[5,6,7,8] (CLEAR verified).
  - `start` pulsed during RUN → ignored; still a single `done`.
- Reset mid-RUN at cycle 10 → all outputs return to reset values asynchronously. A subsequent start then gives a correct result and `done` at cycle 23 after the new start.

Source files
------------

// File: rtl/ntru_pkg.sv
// Shared types for the NTRU convolution sequencer.
// Coefficient width (mod 2048), coefficient type, and sequencer states.
package ntru_pkg;

    localparam int unsigned Q_BITS = 11;

    typedef logic [Q_BITS-1:0] coef_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } conv_state_t;

endpackage

// File: rtl/ntru_conv_seq_mac.sv
// 11-bit multiply-accumulate: result = num3 + num1*num2 mod 2048.
// Ports: num1/num2 multiplicands, num3 accumulator, result (combinational).
module AU_COMP11x11
    import ntru_pkg::*;
(
    input  coef_t num1,
    input  coef_t num2,
    input  coef_t num3,
    output coef_t result
);

    // 11-bit context truncates product and sum to mod 2048.
    assign result = num3 + num1 * num2;

endmodule

// File: rtl/ntru_conv_seq.sv
// Sequencer for c = a*b mod (x^N - 1), coefficients mod 2048, one MAC/cycle.
// Ports: clk, rst, start, busy, done, a/b/c RAM read ports, c RAM write port.
module ntru_conv_seq
    import ntru_pkg::*;
#(
    parameter int unsigned N  = 509,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    input  coef_t         a_data,
    output logic [AW-1:0] b_addr,
    input  coef_t         b_data,
    output logic [AW-1:0] c_raddr,
    input  coef_t         c_rdata,
    output logic [AW-1:0] c_waddr,
    output coef_t         c_wdata,
    output logic          c_we
);

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    conv_state_t   state;
    logic          v1;
    logic [AW-1:0] k1;
    logic          drain_q;
    coef_t         mac;

    AU_COMP11x11 u_mac (
        .num1   (a_data),
        .num2   (b_data),
        .num3   (c_rdata),
        .result (mac)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_addr  <= '0;
            b_addr  <= '0;
            c_raddr <= '0;
            c_waddr <= '0;
            c_wdata <= '0;
            c_we    <= 1'b0;
            v1      <= 1'b0;
            k1      <= '0;
            drain_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    c_we <= 1'b0;
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        c_we    <= 1'b1;
                        c_wdata <= '0;
                        c_waddr <= '0;
                        v1      <= 1'b0;
                        drain_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (c_waddr == LAST) begin
                        state   <= RUN;
                        c_we    <= 1'b0;
                        a_addr  <= '0;
                        b_addr  <= '0;
                        c_raddr <= '0;
                    end else begin
                        c_waddr <= c_waddr + 1'b1;
                    end
                end
                RUN: begin
                    // Issue stage feeds a 2-deep write-back shift.
                    v1      <= 1'b1;
                    k1      <= c_raddr;
                    c_we    <= v1;
                    c_waddr <= k1;
                    c_wdata <= mac;
                    if (b_addr == LAST) begin
                        b_addr  <= '0;
                        // Next row starts at k = i+1 (wrapped).
                        c_raddr <= (a_addr == LAST) ? '0 : a_addr + 1'b1;
                        if (a_addr == LAST) begin
                            state <= DRAIN;
                        end else begin
                            a_addr <= a_addr + 1'b1;
                        end
                    end else begin
                        b_addr  <= b_addr + 1'b1;
                        c_raddr <= (c_raddr == LAST) ? '0 : c_raddr + 1'b1;
                    end
                end
                DRAIN: begin
                    v1      <= 1'b0;
                    c_we    <= v1;
                    c_waddr <= k1;
                    c_wdata <= mac;
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    c_we  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntru_conv_seq.sv
// Self-checking bench for ntru_conv_seq with N=4 and 1-cycle RAM models.
// Compares c RAM, done/busy timing and reset behaviour against a reference.
module tb_ntru_conv_seq;

    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, c_we;
    logic [AW-1:0] a_addr, b_addr, c_raddr, c_waddr;
    logic [10:0]   a_data, b_data, c_rdata, c_wdata;

    logic [10:0]   a_mem [N];
    logic [10:0]   b_mem [N];
    logic [10:0]   c_mem [N];
    logic [10:0]   exp_c [N];
    logic          fill = 1'b0;
    logic [10:0]   fill_val = '0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ntru_conv_seq #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .c_raddr (c_raddr),
        .c_rdata (c_rdata),
        .c_waddr (c_waddr),
        .c_wdata (c_wdata),
        .c_we    (c_we)
    );

    always @(posedge clk) begin
        a_data  <= a_mem[a_addr];
        b_data  <= b_mem[b_addr];
        c_rdata <= c_mem[c_raddr];
        if (fill) begin
            for (int k = 0; k < N; k++) c_mem[k] <= fill_val;
        end else if (c_we) begin
            c_mem[c_waddr] <= c_wdata;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: schoolbook cyclic convolution, all arithmetic mod 2048.
    task automatic model();
        int acc [N];
        for (int k = 0; k < N; k++) acc[k] = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                acc[(i + j) % N] = (acc[(i + j) % N]
                    + int'(a_mem[i]) * int'(b_mem[j])) % 2048;
        for (int k = 0; k < N; k++) exp_c[k] = 11'(acc[k]);
    endtask

    task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
        a_mem[0] = 11'(a0); a_mem[1] = 11'(a1);
        a_mem[2] = 11'(a2); a_mem[3] = 11'(a3);
        b_mem[0] = 11'(b0); b_mem[1] = 11'(b1);
        b_mem[2] = 11'(b2); b_mem[3] = 11'(b3);
    endtask

    task automatic prefill(input logic [10:0] v);
        @(posedge clk);
        #1 fill = 1'b1; fill_val = v;
        @(posedge clk);
        #1 fill = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_we"}, int'(c_we), 0);
        check({tag, "_aaddr"}, int'(a_addr), 0);
        check({tag, "_baddr"}, int'(b_addr), 0);
        check({tag, "_craddr"}, int'(c_raddr), 0);
        check({tag, "_cwaddr"}, int'(c_waddr), 0);
        check({tag, "_cwdata"}, int'(c_wdata), 0);
    endtask

    // Runs one convolution; start accepted at edge ending cycle 0.
    // restart_at: cycle to re-pulse start (ignored). rst_at: abort cycle.
    task automatic run(input string tag, input int restart_at, input int rst_at);
        int done_cyc, done_cnt, busy_cnt, busy_first, busy_last;
        int last_cyc;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        busy_first = -1; busy_last = -1;
        last_cyc = N + N * N + 3;
        model();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1 check_reset_outputs({tag, "_abort"});
                rst = 1'b0;
                return;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = (cyc == restart_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, "_done_cyc"}, done_cyc, last_cyc);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, last_cyc - 1);
        check({tag, "_busy_cnt"}, busy_cnt, last_cyc - 1);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_c%0d", tag, k), int'(c_mem[k]), int'(exp_c[k]));
    endtask

    initial begin
        load(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < N; k++) c_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("reset");

        load(1, 0, 0, 0, 5, 6, 7, 8);
        run("ident", 0, 0);
        check("ident_lit0", int'(c_mem[0]), 5);
        check("ident_lit3", int'(c_mem[3]), 8);

        load(0, 1, 0, 0, 5, 6, 7, 8);
        run("rot", 0, 0);
        check("rot_lit0", int'(c_mem[0]), 8);
        check("rot_lit1", int'(c_mem[1]), 5);

        load(2047, 2047, 2047, 2047, 1, 1, 1, 1);
        run("wrap", 0, 0);
        check("wrap_lit2", int'(c_mem[2]), 2044);

        load(1, 2, 3, 4, 4, 3, 2, 1);
        run("gen", 0, 0);
        check("gen_lit0", int'(c_mem[0]), 24);
        check("gen_lit1", int'(c_mem[1]), 22);
        check("gen_lit3", int'(c_mem[3]), 30);

        prefill(11'h7FF);
        load(1, 0, 0, 0, 5, 6, 7, 8);
        run("clear", 0, 0);

        run("restart", 10, 0);

        load(1, 2, 3, 4, 4, 3, 2, 1);
        run("abort", 0, 10);
        load(1, 0, 0, 0, 5, 6, 7, 8);
        run("after_rst", 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                a_mem[k] = 11'($urandom_range(0, 2047));
                b_mem[k] = 11'($urandom_range(0, 2047));
            end
            if (r % 2 == 0) prefill(11'($urandom_range(0, 2047)));
            run($sformatf("rand%0d", r), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
